// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: register-file addressing and pipeline controller types.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_pkg;

    // Register file addressing
    localparam int REG_ADDR_WIDTH = 5;
    localparam logic [REG_ADDR_WIDTH-1:0] ZERO_REG = 5'd0;

    // Pipeline controller states
    typedef enum logic [1:0] {
        PCTRL_RUN    = 2'd0,
        PCTRL_DRAIN  = 2'd1,
        PCTRL_HALTED = 2'd2
    } pctrl_state_t;

    // Latch control bundle driven by the pipeline controller
    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_flush;
    } pctrl_ctl_t;

    // Free-running pipeline: everything advances, nothing squashed
    localparam pctrl_ctl_t CTL_RUN    = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    // Front end frozen, bubbles into EX, older work continues to WB
    localparam pctrl_ctl_t CTL_DRAIN  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    // Everything frozen and squashed: no memory or regfile side effects
    localparam pctrl_ctl_t CTL_HALTED = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for pipeline performance statistics.
// Latency: count reflects inc one clk edge later; holds at all-ones once reached.
// Backpressure: none; inc is sampled every cycle.
//
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous active-high clear (overrides inc)
//   inc   - increment request for this cycle
//   count - current count value
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use stalls, mispredict squash, HALT drain/freeze.
// Latency: control outputs are combinational (decided this cycle, applied by latches at next edge); halted/drain_timeout/counters registered.
// Backpressure: stalls the front end (pc_write/if_id_write low) on load-use, during drain and once halted.
//
// Ports:
//   clk, reset                      - clock and synchronous active-high reset
//   id_ex_mem_read, id_ex_rt        - load in EX and its destination register
//   if_id_rs, if_id_rt, if_id_uses_rt - source operands of the instruction in ID
//   id_is_halt, wb_is_halt          - HALT in ID / HALT retired in WB
//   branch_mispredict               - EX-resolved mispredict pulse
//   pc_write, if_id_write           - front-end load enables
//   if_id_flush, id_ex_flush, ex_mem_flush - latch squash controls
//   halted, drain_timeout           - frozen status and sticky drain-timeout error
//   cycle_count, stall_count, flush_count  - saturating performance counters
module pipeline_ctrl
    import mips_pkg::*;
#(
    parameter int CNT_W         = 32,
    parameter int DRAIN_TIMEOUT = 8,
    parameter int TO_W          = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      id_ex_mem_read,
    input  logic [REG_ADDR_WIDTH-1:0] id_ex_rt,
    input  logic [REG_ADDR_WIDTH-1:0] if_id_rs,
    input  logic [REG_ADDR_WIDTH-1:0] if_id_rt,
    input  logic                      if_id_uses_rt,
    input  logic                      id_is_halt,
    input  logic                      branch_mispredict,
    input  logic                      wb_is_halt,
    output logic                      pc_write,
    output logic                      if_id_write,
    output logic                      if_id_flush,
    output logic                      id_ex_flush,
    output logic                      ex_mem_flush,
    output logic                      halted,
    output logic                      drain_timeout,
    output logic [CNT_W-1:0]          cycle_count,
    output logic [CNT_W-1:0]          stall_count,
    output logic [CNT_W-1:0]          flush_count
);

    // Last timeout count value spent in DRAIN before the forced exit
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(DRAIN_TIMEOUT - 1);

    pctrl_state_t    state;
    pctrl_state_t    state_nxt;
    logic [TO_W-1:0] to_cnt;
    logic [TO_W-1:0] to_cnt_nxt;
    logic            dto_set;
    logic            load_use;
    pctrl_ctl_t      ctl;
    logic            stall_inc;
    logic            flush_inc;
    logic            cycle_inc;

    // A load writing $0 never creates a real dependency
    assign load_use = id_ex_mem_read
                   && (id_ex_rt != ZERO_REG)
                   && ((id_ex_rt == if_id_rs)
                       || (if_id_uses_rt && (id_ex_rt == if_id_rt)));

    // Next-state and latch controls
    always_comb begin
        state_nxt  = state;
        to_cnt_nxt = to_cnt;
        dto_set    = 1'b0;
        ctl        = CTL_RUN;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;

        case (state)
            PCTRL_RUN: begin
                if (branch_mispredict) begin
                    // Squash wrong-path IF/ID and ID/EX; a hazard or HALT
                    // seen this cycle belongs to the wrong path.
                    ctl.if_id_flush = 1'b1;
                    ctl.id_ex_flush = 1'b1;
                    flush_inc       = 1'b1;
                end else if (id_is_halt) begin
                    // Freeze the front end and let HALT itself move into EX
                    ctl.pc_write    = 1'b0;
                    ctl.if_id_write = 1'b0;
                    state_nxt       = PCTRL_DRAIN;
                    to_cnt_nxt      = '0;
                end else if (load_use) begin
                    // Hold PC and IF/ID, insert one bubble; next cycle the
                    // load has left EX so the hazard clears by itself.
                    ctl.pc_write    = 1'b0;
                    ctl.if_id_write = 1'b0;
                    ctl.id_ex_flush = 1'b1;
                    stall_inc       = 1'b1;
                end
            end

            PCTRL_DRAIN: begin
                // Mispredicts are ignored: HALT was already non-speculative
                ctl        = CTL_DRAIN;
                to_cnt_nxt = to_cnt + 1'b1;
                if (wb_is_halt) begin
                    state_nxt = PCTRL_HALTED;
                end else if (to_cnt == TO_LAST) begin
                    state_nxt = PCTRL_HALTED;
                    dto_set   = 1'b1;
                end
            end

            PCTRL_HALTED: begin
                ctl = CTL_HALTED;
            end

            default: begin
                state_nxt = PCTRL_RUN;
            end
        endcase

        // While in reset the latches clear themselves; present free-run controls
        if (reset) begin
            ctl = CTL_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= PCTRL_RUN;
            to_cnt        <= '0;
            halted        <= 1'b0;
            drain_timeout <= 1'b0;
        end else begin
            state  <= state_nxt;
            to_cnt <= to_cnt_nxt;
            // Reported one cycle after the HALTED state is entered
            halted <= (state == PCTRL_HALTED);
            if (dto_set) begin
                drain_timeout <= 1'b1;
            end
        end
    end

    assign pc_write     = ctl.pc_write;
    assign if_id_write  = ctl.if_id_write;
    assign if_id_flush  = ctl.if_id_flush;
    assign id_ex_flush  = ctl.id_ex_flush;
    assign ex_mem_flush = ctl.ex_mem_flush;

    assign cycle_inc = (state != PCTRL_HALTED);

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (cycle_inc),
        .count (cycle_count)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .count (stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_inc),
        .count (flush_count)
    );

endmodule
